// File: rtl/spi_controller.sv
// SPI mode-0 initiator. Serialises 16-bit register-write frames
// {write, addr[6:0], data[7:0]} MSB-first on sclk/copi under ncs, and returns
// the last eight cipo bits captured in each frame on rsp_data.
// All outputs are registered. They are computed from the next state so that
// they change on the same clock edge as the state they belong to.
module spi_controller #(
  parameter int CLK_DIV  = 4,  // clk cycles per sclk half-period (>=2)
  parameter int CS_SETUP = 2,  // ncs low before first rising sclk (>=1)
  parameter int CS_HOLD  = 2,  // ncs low after last falling sclk (>=1)
  parameter int IDLE_GAP = 4   // ncs high between frames (>=1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       cipo,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;      // cycles spent in the current state/phase
  logic [3:0]      bit_cnt, bit_n;  // frame bit on the wire, counts 15 -> 0
  logic            phase, phase_n;  // 0 = sclk low phase, 1 = sclk high phase
  logic [15:0]     frame, frame_n;
  // Only the last eight captured bits are ever returned, so eight bits of
  // shift register are all that is kept.
  logic [7:0]      cap;

  logic            ready_n, busy_n, ncs_n, sclk_n, copi_n, rsp_valid_n;
  logic [7:0]      rsp_data_n;

  // State, counters and latched frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      frame   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      phase   <= phase_n;
      frame   <= frame_n;
    end
  end

  // Next-state: sequence IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    phase_n = phase;
    frame_n = frame;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          frame_n = {req_write, req_addr, req_data};
          state_n = SETUP;
          cnt_n   = '0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          phase_n = 1'b0;
          bit_n   = 4'd15;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (phase) begin
            phase_n = 1'b0;
            if (bit_cnt == 4'd0) state_n = HOLD;
            else                 bit_n   = bit_cnt - 4'd1;
          end else begin
            phase_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next output values, derived from where the FSM is going. copi follows
  // frame[bit_n], and bit_n only moves at the start of a low phase, so copi
  // is stable across every rising sclk.
  always_comb begin
    ready_n     = (state_n == IDLE);
    busy_n      = (state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD);
    ncs_n       = !busy_n;
    sclk_n      = (state_n == SHIFT) && phase_n;
    copi_n      = 1'b0;
    case (state_n)
      SETUP:   copi_n = frame_n[15];
      SHIFT:   copi_n = frame_n[bit_n];
      HOLD:    copi_n = frame_n[0];
      default: copi_n = 1'b0;
    endcase
    rsp_valid_n = (state == HOLD) && (state_n == GAP);
    rsp_data_n  = rsp_valid_n ? cap : rsp_data;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      req_ready <= ready_n;
      busy      <= busy_n;
      ncs       <= ncs_n;
      sclk      <= sclk_n;
      copi      <= copi_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
    end
  end

  // Sample cipo on the first cycle of each sclk high phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= 8'h00;
    end else if (state == SHIFT && phase && cnt == '0) begin
      cap <= {cap[6:0], cipo};
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a default-parameter instance talks to a
// behavioural mode-0 peripheral (register file + cipo shifter), and a
// fast-parameter instance runs in loopback.
module tb_spi_controller;

  localparam int LOW_DEF   = 2 + 32*4 + 2;   // 132
  localparam int PERIOD    = 1 + LOW_DEF + 4; // 137
  localparam int HIGH_B2B  = 1 + 4;          // one IDLE cycle + GAP
  localparam int LOW_FAST  = 1 + 32*2 + 1;   // 66

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // default instance
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, rsp_valid, sclk, copi, ncs, busy, cipo;
  logic [7:0] rsp_data;

  spi_controller u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cipo(cipo), .sclk(sclk), .copi(copi), .ncs(ncs), .busy(busy)
  );

  // fast instance, cipo looped back from copi
  logic       f_req_valid = 1'b0;
  logic       f_req_ready, f_rsp_valid, f_sclk, f_copi, f_ncs, f_busy;
  logic [7:0] f_rsp_data;

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) u_fast (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(1'b1),
    .req_addr(7'h01), .req_data(8'h55),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
    .cipo(f_copi), .sclk(f_sclk), .copi(f_copi), .ncs(f_ncs), .busy(f_busy)
  );

  // ---------------- peripheral model (mode-0 target) ----------------
  logic [15:0] rx_sh = '0, rx_frame = '0;
  int          rx_edges = 0, edges_last = 0, frames_rx = 0, bad_sclk = 0;
  logic [7:0]  regs [128];

  always @(negedge ncs) rx_edges = 0;
  always @(posedge sclk) begin
    if (ncs === 1'b0) begin
      rx_sh = {rx_sh[14:0], copi};
      rx_edges++;
    end else begin
      bad_sclk++;
    end
  end
  always @(posedge ncs) begin
    edges_last = rx_edges;
    if (rx_edges == 16) begin
      rx_frame = rx_sh;
      frames_rx++;
      if (rx_sh[15]) regs[rx_sh[14:8]] = rx_sh[7:0];
    end
  end

  // target drives cipo: first bit at ncs fall, next bits after each falling sclk
  logic [15:0] cipo_pat = '0;
  logic        cipo_m = 1'b0, loopback = 1'b0;
  int          tx_idx = 15;
  always @(negedge ncs) begin
    tx_idx = 15;
    cipo_m = cipo_pat[15];
  end
  always @(negedge sclk) begin
    if (ncs === 1'b0 && tx_idx > 0) begin
      tx_idx--;
      cipo_m = cipo_pat[tx_idx];
    end
  end
  assign cipo = loopback ? copi : cipo_m;

  // ---------------- waveform monitor, sampled on falling clk ----------------
  int   low_cnt = 0, last_low = 0, high_cnt = 0, last_high = 0;
  int   rsp_cnt = 0, rsp_bad = 0, copi_bad = 0;
  logic p_ncs = 1'b1, p_copi = 1'b0;
  always @(negedge clk) begin
    if (ncs == 1'b0) low_cnt++;
    else if (p_ncs == 1'b0) begin last_low = low_cnt; low_cnt = 0; end
    if (ncs == 1'b1) high_cnt++;
    else if (p_ncs == 1'b1) begin last_high = high_cnt; high_cnt = 0; end
    if (rsp_valid == 1'b1) begin
      rsp_cnt++;
      if (!(p_ncs == 1'b0 && ncs == 1'b1)) rsp_bad++;
    end
    if (sclk == 1'b1 && copi != p_copi) copi_bad++;
    p_ncs  = ncs;
    p_copi = copi;
  end

  // fast instance monitor + receiver
  int          f_low_cnt = 0, f_last_low = 0, f_rsp_cnt = 0, f_edges = 0, f_edges_last = 0;
  logic        f_p_ncs = 1'b1;
  logic [15:0] f_rx_sh = '0, f_rx_frame = '0;
  always @(negedge clk) begin
    if (f_ncs == 1'b0) f_low_cnt++;
    else if (f_p_ncs == 1'b0) begin f_last_low = f_low_cnt; f_low_cnt = 0; end
    if (f_rsp_valid == 1'b1) f_rsp_cnt++;
    f_p_ncs = f_ncs;
  end
  always @(negedge f_ncs) f_edges = 0;
  always @(posedge f_sclk) if (f_ncs === 1'b0) begin f_rx_sh = {f_rx_sh[14:0], f_copi}; f_edges++; end
  always @(posedge f_ncs) begin f_edges_last = f_edges; f_rx_frame = f_rx_sh; end

  // ---------------- stimulus helpers ----------------
  // Presents a request and returns once the accepting edge has passed.
  task automatic send(input logic [15:0] f, input bit keep, output int hs_cyc);
    @(negedge clk);
    req_valid = 1'b1;
    {req_write, req_addr, req_data} = f;
    hs_cyc = -1;
    for (int i = 0; i < 500 && hs_cyc < 0; i++) begin
      if (req_ready == 1'b1) hs_cyc = cyc;
      @(negedge clk);
    end
    if (!keep) req_valid = 1'b0;
    if (hs_cyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL handshake: timed out, want req_ready within 500 cycles");
    end
  endtask

  task automatic wait_rsp(input int n0);
    int t = 0;
    while (rsp_cnt <= n0 && t < 500) begin @(negedge clk); t++; end
    if (rsp_cnt <= n0) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_wait: no rsp_valid within 500 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_chk++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    n_chk++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    n_chk++; if (copi !== 1'b0) begin n_fail++; $display("FAIL rst_copi: got %b want 0", copi); end
    n_chk++; if (ncs !== 1'b1) begin n_fail++; $display("FAIL rst_ncs: got %b want 1", ncs); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int h, n0, f0;
    cipo_pat = 16'($urandom);
    n0 = rsp_cnt; f0 = frames_rx;
    send(16'h80FF, 1'b0, h);
    n_chk++; if (busy !== 1'b1 || ncs !== 1'b0) begin n_fail++; $display("FAIL single_busy: busy=%b ncs=%b want 1/0", busy, ncs); end
    wait_rsp(n0);
    n_chk++; if (last_low != LOW_DEF) begin n_fail++; $display("FAIL single_ncs_low: got %0d want %0d", last_low, LOW_DEF); end
    n_chk++; if (edges_last != 16) begin n_fail++; $display("FAIL single_edges: got %0d want 16", edges_last); end
    n_chk++; if (rx_frame !== 16'h80FF) begin n_fail++; $display("FAIL single_frame: got %h want 80ff", rx_frame); end
    n_chk++; if (rsp_data !== cipo_pat[7:0]) begin n_fail++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, cipo_pat[7:0]); end
    repeat (10) @(negedge clk);
    n_chk++; if (rsp_cnt != n0 + 1 || rsp_bad != 0) begin n_fail++; $display("FAIL single_rsp_pulse: count %0d misaligned %0d want 1/0", rsp_cnt - n0, rsp_bad); end
    n_chk++; if (frames_rx != f0 + 1) begin n_fail++; $display("FAIL single_frames: got %0d want %0d", frames_rx - f0, 1); end
  endtask

  task automatic test_back_to_back();
    int h1, h2, n0;
    n0 = rsp_cnt;
    send(16'h8480, 1'b1, h1);
    send(16'h820F, 1'b0, h2);
    wait_rsp(n0 + 1);
    n_chk++; if (h2 - h1 != PERIOD) begin n_fail++; $display("FAIL b2b_period: got %0d want %0d", h2 - h1, PERIOD); end
    n_chk++; if (last_high != HIGH_B2B) begin n_fail++; $display("FAIL b2b_ncs_high: got %0d want %0d", last_high, HIGH_B2B); end
    n_chk++; if (regs[4] !== 8'h80) begin n_fail++; $display("FAIL b2b_duty: got %h want 80", regs[4]); end
    n_chk++; if (regs[2] !== 8'h0F) begin n_fail++; $display("FAIL b2b_en_pwm: got %h want 0f", regs[2]); end
  endtask

  task automatic test_loopback();
    int h, n0;
    loopback = 1'b1;
    n0 = rsp_cnt;
    send(16'h15A5, 1'b0, h);
    wait_rsp(n0);
    n_chk++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL loop_rsp_data: got %h want a5", rsp_data); end
    n_chk++; if (rx_frame !== 16'h15A5) begin n_fail++; $display("FAIL loop_frame: got %h want 15a5", rx_frame); end
    loopback = 1'b0;
  endtask

  // random frames while the request bus churns every cycle
  task automatic test_stability();
    for (int k = 0; k < 4; k++) begin
      int h, n0, t;
      logic [15:0] f;
      f = 16'($urandom);
      cipo_pat = 16'($urandom);
      n0 = rsp_cnt;
      send(f, 1'b0, h);
      t = 0;
      while (rsp_cnt <= n0 && t < 500) begin
        {req_write, req_addr, req_data} = 16'($urandom);
        @(negedge clk); t++;
      end
      n_chk++; if (rx_frame !== f) begin n_fail++; $display("FAIL stab_frame[%0d]: got %h want %h", k, rx_frame, f); end
      n_chk++; if (rsp_data !== cipo_pat[7:0]) begin n_fail++; $display("FAIL stab_rsp[%0d]: got %h want %h", k, rsp_data, cipo_pat[7:0]); end
      if (f[15]) begin
        n_chk++; if (regs[f[14:8]] !== f[7:0]) begin n_fail++; $display("FAIL stab_reg[%0d]: got %h want %h", k, regs[f[14:8]], f[7:0]); end
      end
    end
    n_chk++; if (copi_bad != 0) begin n_fail++; $display("FAIL copi_stable: %0d changes while sclk high, want 0", copi_bad); end
    n_chk++; if (bad_sclk != 0) begin n_fail++; $display("FAIL sclk_ncs_high: %0d pulses, want 0", bad_sclk); end
  endtask

  task automatic test_reset_mid();
    int h, n0, f0, t;
    n0 = rsp_cnt; f0 = frames_rx;
    send(16'hC3AA, 1'b0, h);
    t = 0;
    while (rx_edges < 7 && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (rx_edges != 7) begin n_fail++; $display("FAIL mid_edges: got %0d want 7", rx_edges); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (ncs !== 1'b1 || sclk !== 1'b0) begin n_fail++; $display("FAIL mid_async: ncs=%b sclk=%b want 1/0", ncs, sclk); end
    n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_ready: ready=%b busy=%b want 1/0", req_ready, busy); end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (rsp_cnt != n0 || frames_rx != f0) begin n_fail++; $display("FAIL mid_no_rsp: rsp %0d frames %0d want 0/0", rsp_cnt - n0, frames_rx - f0); end
    send(16'h813C, 1'b0, h);
    wait_rsp(n0);
    n_chk++; if (rx_frame !== 16'h813C || regs[1] !== 8'h3C) begin n_fail++; $display("FAIL mid_after: frame %h reg %h want 813c/3c", rx_frame, regs[1]); end
    n_chk++; if (last_low != LOW_DEF) begin n_fail++; $display("FAIL mid_after_low: got %0d want %0d", last_low, LOW_DEF); end
  endtask

  task automatic test_fast();
    int n0, t;
    n0 = f_rsp_cnt;
    @(negedge clk);
    f_req_valid = 1'b1;
    t = 0;
    while (f_req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    f_req_valid = 1'b0;
    t = 0;
    while (f_rsp_cnt <= n0 && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (f_last_low != LOW_FAST) begin n_fail++; $display("FAIL fast_ncs_low: got %0d want %0d", f_last_low, LOW_FAST); end
    n_chk++; if (f_rx_frame !== 16'h8155 || f_edges_last != 16) begin n_fail++; $display("FAIL fast_frame: got %h edges %0d want 8155/16", f_rx_frame, f_edges_last); end
    n_chk++; if (f_rsp_data !== 8'h55 || f_rsp_cnt != n0 + 1) begin n_fail++; $display("FAIL fast_rsp: got %h count %0d want 55/1", f_rsp_data, f_rsp_cnt - n0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_loopback();
    test_stability();
    test_reset_mid();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
